// File: rtl/axi_tcm_responder.sv
// AXI4 slave bridging single-outstanding bursts onto a one-cycle-latency TCM port.
// Optional WRAP burst support: define AXI_TCM_WRAP_BURST_EN.
module axi_tcm_responder #(
  parameter int AXI_ID_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // AW
  input  logic                awvalid_i,
  input  logic [31:0]         awaddr_i,
  input  logic [AXI_ID_W-1:0] awid_i,
  input  logic [7:0]          awlen_i,
  input  logic [1:0]          awburst_i,
  output logic                awready_o,
  // W
  input  logic                wvalid_i,
  input  logic [31:0]         wdata_i,
  input  logic [3:0]          wstrb_i,
  input  logic                wlast_i,
  output logic                wready_o,
  // B
  output logic                bvalid_o,
  output logic [1:0]          bresp_o,
  output logic [AXI_ID_W-1:0] bid_o,
  input  logic                bready_i,
  // AR
  input  logic                arvalid_i,
  input  logic [31:0]         araddr_i,
  input  logic [AXI_ID_W-1:0] arid_i,
  input  logic [7:0]          arlen_i,
  input  logic [1:0]          arburst_i,
  output logic                arready_o,
  // R
  output logic                rvalid_o,
  output logic [31:0]         rdata_o,
  output logic [1:0]          rresp_o,
  output logic [AXI_ID_W-1:0] rid_o,
  output logic                rlast_o,
  input  logic                rready_i,
  // TCM
  output logic [3:0]          ram_wr_o,
  output logic                ram_rd_o,
  output logic [31:0]         ram_addr_o,
  output logic [31:0]         ram_write_data_o,
  input  logic [31:0]         ram_read_data_i
);

  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

  state_t                state_q, state_d;
  logic [29:0]           addr_q, addr_nxt;
  logic [AXI_ID_W-1:0]   id_q;
  logic [7:0]            len_q;
  logic [1:0]            burst_q;
  logic [7:0]            beat_q;
  logic [7:0]            r_beat_q;
  logic                  issue_done_q;
  logic                  inflight_q;
  logic [31:0]           buf_mem [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;
  logic                  accept_aw, accept_ar, w_beat, push, pop;

  // Byte offsets are ignored (word-aligned TCM) and wlast is not used for termination.
  logic unused_inputs;
  assign unused_inputs = ^{awaddr_i[1:0], araddr_i[1:0], wlast_i};

`ifdef AXI_TCM_WRAP_BURST_EN
  logic [29:0] wrap_mask;
  assign wrap_mask = {26'd0, len_q[3:0]};
`endif

  always_comb begin
    addr_nxt = addr_q + 30'd1;
    if (burst_q == 2'b00) begin
      addr_nxt = addr_q;
    end
`ifdef AXI_TCM_WRAP_BURST_EN
    else if (burst_q == 2'b10) begin
      addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + 30'd1) & wrap_mask);
    end
`endif
  end

  assign rvalid_o         = (count_q != 2'd0);
  assign rdata_o          = buf_mem[rd_ptr_q];
  assign rid_o            = id_q;
  assign rresp_o          = 2'b00;
  assign rlast_o          = rvalid_o && (r_beat_q == len_q);
  assign bid_o            = id_q;
  assign bresp_o          = 2'b00;
  assign ram_addr_o       = {addr_q, 2'b00};
  assign ram_write_data_o = wdata_i;
  assign pop              = rvalid_o && rready_i;
  assign push             = inflight_q;

  always_comb begin
    state_d   = state_q;
    awready_o = 1'b0;
    arready_o = 1'b0;
    wready_o  = 1'b0;
    bvalid_o  = 1'b0;
    ram_wr_o  = 4'b0000;
    ram_rd_o  = 1'b0;
    accept_aw = 1'b0;
    accept_ar = 1'b0;
    w_beat    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (awvalid_i) begin
          awready_o = 1'b1;
          accept_aw = 1'b1;
          state_d   = WRITE;
        end else if (arvalid_i) begin
          arready_o = 1'b1;
          accept_ar = 1'b1;
          state_d   = READ;
        end
      end
      WRITE: begin
        wready_o = 1'b1;
        if (wvalid_i) begin
          ram_wr_o = wstrb_i;
          w_beat   = 1'b1;
          if (beat_q == len_q) state_d = WRESP;
        end
      end
      WRESP: begin
        bvalid_o = 1'b1;
        if (bready_i) state_d = IDLE;
      end
      READ: begin
        // Credit: buffered plus in-flight words may never exceed the two buffer slots.
        if (!issue_done_q && (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2)) ram_rd_o = 1'b1;
        if (rlast_o && rready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      ram_wr_o = 4'b0000;
      ram_rd_o = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      beat_q       <= 8'd0;
      r_beat_q     <= 8'd0;
      issue_done_q <= 1'b0;
      inflight_q   <= 1'b0;
      count_q      <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      addr_q       <= 30'd0;
      id_q         <= '0;
      len_q        <= 8'd0;
      burst_q      <= 2'b01;
    end else begin
      state_q    <= state_d;
      inflight_q <= ram_rd_o;
      if (accept_aw) begin
        addr_q  <= awaddr_i[31:2];
        id_q    <= awid_i;
        len_q   <= awlen_i;
        burst_q <= awburst_i;
        beat_q  <= 8'd0;
      end else if (accept_ar) begin
        addr_q       <= araddr_i[31:2];
        id_q         <= arid_i;
        len_q        <= arlen_i;
        burst_q      <= arburst_i;
        beat_q       <= 8'd0;
        r_beat_q     <= 8'd0;
        issue_done_q <= 1'b0;
      end else if (w_beat || ram_rd_o) begin
        addr_q <= addr_nxt;
        // Hold at len on the final beat so len=255 never wraps the counter.
        if (beat_q == len_q) issue_done_q <= 1'b1;
        else beat_q <= beat_q + 8'd1;
      end
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        r_beat_q <= r_beat_q + 8'd1;
      end
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  // NOTE: buffer storage is not reset; occupancy alone decides which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) buf_mem[wr_ptr_q] <= ram_read_data_i;
  end

endmodule

// File: tb/tb_axi_tcm_responder.sv
// Directed self-checking bench for axi_tcm_responder with a one-cycle-latency TCM model.
module tb_axi_tcm_responder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        awvalid_i = 1'b0, wvalid_i = 1'b0, wlast_i = 1'b0, bready_i = 1'b0;
  logic        arvalid_i = 1'b0, rready_i = 1'b0;
  logic [31:0] awaddr_i = '0, araddr_i = '0, wdata_i = '0, ram_read_data_i = '0;
  logic [3:0]  awid_i = '0, arid_i = '0, wstrb_i = '0;
  logic [7:0]  awlen_i = '0, arlen_i = '0;
  logic [1:0]  awburst_i = 2'b01, arburst_i = 2'b01;
  logic        awready_o, wready_o, bvalid_o, arready_o, rvalid_o, rlast_o, ram_rd_o;
  logic [1:0]  bresp_o, rresp_o;
  logic [3:0]  bid_o, rid_o, ram_wr_o;
  logic [31:0] rdata_o, ram_addr_o, ram_write_data_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rd_log[$];

  axi_tcm_responder #(.AXI_ID_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .awvalid_i(awvalid_i), .awaddr_i(awaddr_i), .awid_i(awid_i), .awlen_i(awlen_i),
    .awburst_i(awburst_i), .awready_o(awready_o),
    .wvalid_i(wvalid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i), .wready_o(wready_o),
    .bvalid_o(bvalid_o), .bresp_o(bresp_o), .bid_o(bid_o), .bready_i(bready_i),
    .arvalid_i(arvalid_i), .araddr_i(araddr_i), .arid_i(arid_i), .arlen_i(arlen_i),
    .arburst_i(arburst_i), .arready_o(arready_o),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rid_o(rid_o), .rlast_o(rlast_o),
    .rready_i(rready_i),
    .ram_wr_o(ram_wr_o), .ram_rd_o(ram_rd_o), .ram_addr_o(ram_addr_o),
    .ram_write_data_o(ram_write_data_o), .ram_read_data_i(ram_read_data_i)
  );

  always #5 clk_i = ~clk_i;

  // TCM model: read data is the inverted word address, returned one cycle after ram_rd_o.
  always @(posedge clk_i) if (ram_rd_o) ram_read_data_i <= ~ram_addr_o;
  always @(negedge clk_i) if (ram_rd_o) rd_log.push_back(ram_addr_o);

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Accepts R beats with rready held high; tallies beats, rlast count and data/id errors.
  task automatic drain_read(input int max_cycles, input logic [3:0] exp_id,
                            output int beats, output int lasts, output int derr, output bit done);
    beats = 0; lasts = 0; derr = 0; done = 1'b0;
    rready_i = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      #1;
      if (rvalid_o && rready_i) begin
        if (beats >= rd_log.size()) derr++;
        else if (rdata_o !== ~rd_log[beats]) derr++;
        if (rid_o !== exp_id || rresp_o !== 2'b00) derr++;
        if (rlast_o) begin lasts++; done = 1'b1; end
        beats++;
      end
      tick();
      if (done) break;
    end
    rready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    #1;
    n_checks++;
    if ({awready_o, arready_o, wready_o, bvalid_o, rvalid_o, rlast_o, ram_rd_o, ram_wr_o} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: aw=%b ar=%b w=%b b=%b rv=%b rl=%b rd=%b wr=%h expected all 0",
               awready_o, arready_o, wready_o, bvalid_o, rvalid_o, rlast_o, ram_rd_o, ram_wr_o);
    end
    tick();
  endtask

  task automatic test_write();
    awvalid_i = 1'b1; awaddr_i = 32'h100; awlen_i = 8'd3; awburst_i = 2'b01; awid_i = 4'd5;
    #1;
    n_checks++;
    if (awready_o !== 1'b1) begin n_fail++; $display("FAIL wr_aw_accept: awready_o=%b expected 1", awready_o); end
    tick();
    awvalid_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      wvalid_i = 1'b1; wdata_i = 32'hCAFE_0000 + 32'(b); wstrb_i = 4'hF; wlast_i = (b == 3);
      #1;
      n_checks++;
      if (wready_o !== 1'b1 || ram_wr_o !== 4'hF || ram_addr_o !== 32'h100 + 32'(4 * b) ||
          ram_write_data_o !== 32'hCAFE_0000 + 32'(b)) begin
        n_fail++;
        $display("FAIL wr_beat%0d: wready=%b wr=%h addr=%h data=%h expected 1 f %h %h", b, wready_o,
                 ram_wr_o, ram_addr_o, ram_write_data_o, 32'h100 + 32'(4 * b), 32'hCAFE_0000 + 32'(b));
      end
      tick();
    end
    wvalid_i = 1'b0; wlast_i = 1'b0;
    #1;
    n_checks++;
    if (bvalid_o !== 1'b1 || bid_o !== 4'd5 || bresp_o !== 2'b00 || ram_wr_o !== 4'h0) begin
      n_fail++;
      $display("FAIL wr_bresp: bvalid=%b bid=%0d bresp=%0d wr=%h expected 1 5 0 0", bvalid_o, bid_o, bresp_o, ram_wr_o);
    end
    bready_i = 1'b1;
    tick();
    bready_i = 1'b0;
    #1;
    n_checks++;
    if (bvalid_o !== 1'b0 || wready_o !== 1'b0) begin
      n_fail++; $display("FAIL wr_done: bvalid=%b wready=%b expected 0 0", bvalid_o, wready_o);
    end
    tick();
  endtask

  task automatic test_read_backpressure();
    int beats, lasts, derr;
    bit done;
    rd_log.delete();
    rready_i = 1'b0;
    arvalid_i = 1'b1; araddr_i = 32'h200; arlen_i = 8'd1; arburst_i = 2'b01; arid_i = 4'd2;
    #1;
    n_checks++;
    if (arready_o !== 1'b1) begin n_fail++; $display("FAIL rd_ar_accept: arready_o=%b expected 1", arready_o); end
    tick();
    arvalid_i = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (rd_log.size() != 2) begin
      n_fail++; $display("FAIL rd_bp_pulses: ram_rd pulses=%0d expected 2", rd_log.size());
    end else if (rd_log[0] !== 32'h200 || rd_log[1] !== 32'h204) begin
      n_fail++; $display("FAIL rd_bp_pulses: addrs=%h,%h expected 200,204", rd_log[0], rd_log[1]);
    end
    #1;
    n_checks++;
    if (rvalid_o !== 1'b1 || rlast_o !== 1'b0) begin
      n_fail++; $display("FAIL rd_bp_hold: rvalid=%b rlast=%b expected 1 0", rvalid_o, rlast_o);
    end
    drain_read(10, 4'd2, beats, lasts, derr, done);
    n_checks++;
    if (!done || beats != 2 || lasts != 1 || derr != 0) begin
      n_fail++;
      $display("FAIL rd_bp_drain: done=%b beats=%0d lasts=%0d errs=%0d expected 1 2 1 0", done, beats, lasts, derr);
    end
  endtask

  task automatic test_collision();
    int beats, lasts, derr;
    bit done;
    rd_log.delete();
    awvalid_i = 1'b1; awaddr_i = 32'h20; awlen_i = 8'd0; awburst_i = 2'b01; awid_i = 4'd1;
    arvalid_i = 1'b1; araddr_i = 32'h300; arlen_i = 8'd0; arburst_i = 2'b00; arid_i = 4'd4;
    #1;
    n_checks++;
    if (awready_o !== 1'b1 || arready_o !== 1'b0) begin
      n_fail++; $display("FAIL col_priority: awready=%b arready=%b expected 1 0", awready_o, arready_o);
    end
    tick();
    awvalid_i = 1'b0;
    wvalid_i = 1'b1; wdata_i = 32'h1234; wstrb_i = 4'h3; wlast_i = 1'b1;
    #1;
    n_checks++;
    if (ram_wr_o !== 4'h3 || ram_addr_o !== 32'h20 || arready_o !== 1'b0) begin
      n_fail++; $display("FAIL col_write: wr=%h addr=%h arready=%b expected 3 20 0", ram_wr_o, ram_addr_o, arready_o);
    end
    tick();
    wvalid_i = 1'b0; wlast_i = 1'b0;
    #1;
    n_checks++;
    if (bvalid_o !== 1'b1 || bid_o !== 4'd1 || arready_o !== 1'b0) begin
      n_fail++; $display("FAIL col_wresp: bvalid=%b bid=%0d arready=%b expected 1 1 0", bvalid_o, bid_o, arready_o);
    end
    bready_i = 1'b1;
    tick();
    bready_i = 1'b0;
    #1;
    n_checks++;
    if (arready_o !== 1'b1) begin n_fail++; $display("FAIL col_ar_after_b: arready=%b expected 1", arready_o); end
    tick();
    arvalid_i = 1'b0;
    drain_read(10, 4'd4, beats, lasts, derr, done);
    n_checks++;
    if (!done || beats != 1 || derr != 0 || rd_log.size() != 1) begin
      n_fail++;
      $display("FAIL col_read: done=%b beats=%0d errs=%0d pulses=%0d expected 1 1 0 1", done, beats, derr, rd_log.size());
    end else if (rd_log[0] !== 32'h300) begin
      n_fail++; $display("FAIL col_read_addr: addr=%h expected 300", rd_log[0]);
    end
  endtask

  task automatic test_wrap();
    int beats, lasts, derr;
    bit done;
    logic [31:0] exp_addr [4];
`ifdef AXI_TCM_WRAP_BURST_EN
    exp_addr = '{32'h38, 32'h3C, 32'h30, 32'h34};
`else
    exp_addr = '{32'h38, 32'h3C, 32'h40, 32'h44};
`endif
    rd_log.delete();
    arvalid_i = 1'b1; araddr_i = 32'h38; arlen_i = 8'd3; arburst_i = 2'b10; arid_i = 4'd6;
    #1;
    n_checks++;
    if (arready_o !== 1'b1) begin n_fail++; $display("FAIL wrap_accept: arready=%b expected 1", arready_o); end
    tick();
    arvalid_i = 1'b0;
    drain_read(30, 4'd6, beats, lasts, derr, done);
    n_checks++;
    if (!done || beats != 4 || lasts != 1 || derr != 0 || rd_log.size() != 4) begin
      n_fail++;
      $display("FAIL wrap_beats: done=%b beats=%0d lasts=%0d errs=%0d pulses=%0d expected 1 4 1 0 4",
               done, beats, lasts, derr, rd_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (rd_log[i] !== exp_addr[i]) begin
          n_fail++; $display("FAIL wrap_addr%0d: addr=%h expected %h", i, rd_log[i], exp_addr[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int beats, lasts, derr;
    bit done;
    rd_log.delete();
    rready_i = 1'b1;
    arvalid_i = 1'b1; araddr_i = 32'h400; arlen_i = 8'd3; arburst_i = 2'b01; arid_i = 4'd7;
    #1;
    n_checks++;
    if (arready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ar_accept: arready=%b expected 1", arready_o); end
    tick();
    arvalid_i = 1'b0;
    repeat (3) tick();
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (ram_rd_o !== 1'b0) begin n_fail++; $display("FAIL rst_gate_rd: ram_rd=%b expected 0", ram_rd_o); end
    tick();
    rst_i = 1'b0;
    #1;
    n_checks++;
    if ({awready_o, arready_o, wready_o, bvalid_o, rvalid_o, rlast_o, ram_rd_o, ram_wr_o} !== 11'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: aw=%b ar=%b w=%b b=%b rv=%b rl=%b rd=%b wr=%h expected all 0",
               awready_o, arready_o, wready_o, bvalid_o, rvalid_o, rlast_o, ram_rd_o, ram_wr_o);
    end
    n_checks++;
    if (rd_log.size() != 2) begin
      n_fail++; $display("FAIL rst_mid_pulses: ram_rd pulses=%0d expected 2", rd_log.size());
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (rvalid_o !== 1'b0 || ram_rd_o !== 1'b0) begin
        n_fail++; $display("FAIL rst_quiet%0d: rvalid=%b ram_rd=%b expected 0 0", i, rvalid_o, ram_rd_o);
      end
    end
    rready_i = 1'b0;
    tick();
    rd_log.delete();
    arvalid_i = 1'b1; araddr_i = 32'h500; arlen_i = 8'd0; arburst_i = 2'b01; arid_i = 4'd3;
    #1;
    n_checks++;
    if (arready_o !== 1'b1) begin n_fail++; $display("FAIL rst_new_ar: arready=%b expected 1", arready_o); end
    tick();
    arvalid_i = 1'b0;
    drain_read(10, 4'd3, beats, lasts, derr, done);
    n_checks++;
    if (!done || beats != 1 || derr != 0) begin
      n_fail++; $display("FAIL rst_new_read: done=%b beats=%0d errs=%0d expected 1 1 0", done, beats, derr);
    end
  endtask

  task automatic test_long_read();
    int beats, lasts, derr;
    bit done;
    rd_log.delete();
    arvalid_i = 1'b1; araddr_i = 32'h1000; arlen_i = 8'd255; arburst_i = 2'b01; arid_i = 4'd9;
    #1;
    tick();
    arvalid_i = 1'b0;
    drain_read(1200, 4'd9, beats, lasts, derr, done);
    n_checks++;
    if (!done || beats != 256 || lasts != 1 || derr != 0) begin
      n_fail++;
      $display("FAIL long_beats: done=%b beats=%0d lasts=%0d errs=%0d expected 1 256 1 0", done, beats, lasts, derr);
    end
    n_checks++;
    if (rd_log.size() != 256) begin
      n_fail++; $display("FAIL long_pulses: ram_rd pulses=%0d expected 256", rd_log.size());
    end else if (rd_log[255] !== 32'h13FC) begin
      n_fail++; $display("FAIL long_last_addr: addr=%h expected 13fc", rd_log[255]);
    end
    #1;
    n_checks++;
    if (rvalid_o !== 1'b0 || ram_rd_o !== 1'b0) begin
      n_fail++; $display("FAIL long_idle: rvalid=%b ram_rd=%b expected 0 0", rvalid_o, ram_rd_o);
    end
  endtask

  initial begin
    @(posedge clk_i); #1;
    test_reset();
    test_write();
    test_read_backpressure();
    test_collision();
    test_wrap();
    test_reset_mid_read();
    test_long_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
